register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised successor register file for the RISC CPU: NUM_RD combinational read ports,
//  2 write ports, write-to-read bypass, optional hardwired-zero x0, and a per-register
//  pending-write scoreboard.
//  It sits between decode/issue (reads, marks destinations busy) and writeback (clears busy).
//  Issue logic uses the scoreboard outputs to detect RAW/WAW hazards.
// PARAMETERS
//  DW       32  data width of each register
//  AW       5   address width; depth = 2**AW registers
//  NUM_RD   2   number of read ports (1..4)
//  ZERO_REG 1   1: reg 0 reads 0, ignores writes, never busy; 0: reg 0 is ordinary
// PORTS
//  clock     in   1          rising-edge clock, single domain
//  reset_n   in   1          synchronous active-low reset
//  rd_addr   in   NUM_RD*AW  read addresses; port i = [i*AW +: AW]
//  rd_data   out  NUM_RD*DW  read data, port i = [i*DW +: DW]
//  rd_busy   out  NUM_RD     port i register has a pending write not satisfied this cycle
//  we0       in   1          write port 0 enable
//  wa0       in   AW         write port 0 address
//  wd0       in   DW         write port 0 data
//  we1       in   1          write port 1 enable (priority over port 0)
//  wa1       in   AW         write port 1 address
//  wd1       in   DW         write port 1 data
//  iss_en    in   1          issue: mark iss_rd as pending-write
//  iss_rd    in   AW         destination register being issued
//  iss_waw   out  1          iss_en & busy[iss_rd] (WAW hazard, combinational)
//  busy_cnt  out  AW+1       number of busy registers (registered)
// BEHAVIOUR
//  - Reset: at rising clock with reset_n=0, all registers, busy bits and busy_cnt := 0.
//    Writes and issues in that cycle are dropped. Reset mid-operation discards all pending state.
//  - Write: on rising edge, if weN and the address is writable, the register takes wdN.
//    we0 and we1 to the same address: wd1 is stored. Writes to reg 0 with ZERO_REG=1 are dropped.
//  - Read: combinational, 0-cycle latency.
//    Priority: ZERO_REG & addr==0 -> 0; else we1 hit -> wd1; else we0 hit -> wd0; else stored value.
//  - Scoreboard busy[r] next-state:
//    - issue on r sets it.
//    - any write to r clears it.
//    - issue and write to the same r in the same cycle: set wins (new producer).
//    - issue of reg 0 is ignored when ZERO_REG=1.
//  - rd_busy[i] = busy[rd_addr_i] & no write hit on rd_addr_i this cycle.
//  - iss_waw is informational only; the issue still sets busy.
//  - busy_cnt tracks popcount(busy) exactly (+1 set, -1 clear, per edge).
//    It can never exceed 2**AW and never underflow. Writes to non-busy registers do not decrement it.
//  - No X on any output once reset_n has been sampled low once.
// TESTING
//  1 Reset: hold reset_n=0 2 cycles, then read all 32 regs -> every rd_data=0, rd_busy=0, busy_cnt=0.
//  2 Write/read: we0=1 wa0=2 wd0=0x1 for one edge; then rd_addr0=2 -> rd_data0=0x1.
//    Write reg 0 with 0xFF -> reads 0.
//  3 Bypass/priority: same cycle we0 wa0=3 wd0=0xA, we1 wa1=3 wd1=0xB, rd_addr1=3 -> rd_data1=0xB
//    before the edge; stored value 0xB after the edge.
//  4 Scoreboard: iss_en iss_rd=5 -> busy_cnt=1.
//    rd_addr0=5 -> rd_busy0=1.
//    Same cycle as we0 wa0=5 wd0=0x7 -> rd_busy0=0, rd_data0=0x7.
//    Next cycle busy_cnt=0.
//  5 Collisions: iss_en iss_rd=6 and we1 wa1=6 same cycle -> busy[6]=1, busy_cnt +1.
//    Re-issue 6 -> iss_waw=1.
//  6 Reset mid-operation: busy regs 5,6,7 with pending writes, reset_n=0 one cycle
//    -> busy_cnt=0 and all data=0 the next cycle.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read/dual-write register file with write bypass,
// optional hardwired-zero reg 0 and a per-register pending-write scoreboard
module register_file_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [DW-1:0]        wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [DW-1:0]        wd1,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_waw,
    output logic [AW:0]          busy_cnt
);
    localparam int DEPTH = 2**AW;
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy, busy_next;
    logic [AW:0]      cnt_next;
    logic             w0_ok, w1_ok, iss_ok;
    assign w0_ok   = we0 && !(ZERO_REG && wa0 == '0);
    assign w1_ok   = we1 && !(ZERO_REG && wa1 == '0);
    assign iss_ok  = iss_en && !(ZERO_REG && iss_rd == '0);
    assign iss_waw = iss_en && busy[iss_rd];
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          h0, h1;
        assign a  = rd_addr[i*AW +: AW];
        assign h0 = we0 && wa0 == a;
        assign h1 = we1 && wa1 == a;
        assign rd_data[i*DW +: DW] = (ZERO_REG && a == '0) ? '0 : h1 ? wd1 : h0 ? wd0 : mem[a];
        assign rd_busy[i] = busy[a] && !(h0 || h1);
    end
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        always_ff @(posedge clock) begin
            if (!reset_n)
                mem[r] <= '0;
            else if (w1_ok && wa1 == AW'(r))
                mem[r] <= wd1;
            else if (w0_ok && wa0 == AW'(r))
                mem[r] <= wd0;
        end
    end
    // issue beats a same-cycle write: the issued instruction is the newer producer
    always_comb begin
        busy_next = '0;
        cnt_next  = '0;
        for (int r = 0; r < DEPTH; r++) begin
            busy_next[r] = (iss_ok && iss_rd == AW'(r)) ? 1'b1 :
                           ((w0_ok && wa0 == AW'(r)) || (w1_ok && wa1 == AW'(r))) ? 1'b0 : busy[r];
            cnt_next = cnt_next + (AW+1)'(busy_next[r]);
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed stimulus with a queued-expectation scoreboard
module tb_register_file_mp;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0 = 1'b0, we1 = 1'b0, iss_en = 1'b0;
    logic [4:0]  wa0 = '0, wa1 = '0, iss_rd = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic        iss_waw;
    logic [5:0]  busy_cnt;
    int          checks = 0, errors = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] v;
    } exp_t;
    exp_t q[$];

    register_file_mp #(.DW(32), .AW(5), .NUM_RD(2), .ZERO_REG(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1),
        .wd1(wd1), .iss_en(iss_en), .iss_rd(iss_rd), .iss_waw(iss_waw), .busy_cnt(busy_cnt)
    );

    always #5 clock = ~clock;

    // selectors: 0/1 rd_data port, 2/3 rd_busy port, 4 busy_cnt, 5 iss_waw
    function automatic logic [31:0] probe(int sel);
        case (sel)
            0: return rd_data[31:0];
            1: return rd_data[63:32];
            2: return {31'b0, rd_busy[0]};
            3: return {31'b0, rd_busy[1]};
            4: return {26'b0, busy_cnt};
            default: return {31'b0, iss_waw};
        endcase
    endfunction

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.v    = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clock);
        we0 = 1'b0;
        we1 = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic ra(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] got;
        forever begin
            @(negedge clock);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                got = probe(e.sel);
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, got, e.v, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        repeat (2) @(posedge clock);
        step();
        reset_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            if (r > 0) step();
            ra(5'(r), 5'(31 - r));
            expect_v("reset_data0", 0, 32'h0);
            expect_v("reset_data1", 1, 32'h0);
            expect_v("reset_busy0", 2, 32'h0);
            expect_v("reset_busy1", 3, 32'h0);
            expect_v("reset_cnt", 4, 32'h0);
        end
        step();
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h1; ra(5'd2, 5'd0);
        expect_v("wr_bypass0", 0, 32'h1);
        step();
        expect_v("wr_stored2", 0, 32'h1);
        step();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFF; ra(5'd0, 5'd2);
        expect_v("zero_bypass", 0, 32'h0);
        expect_v("other_port", 1, 32'h1);
        step();
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hEE;
        expect_v("zero_stored", 0, 32'h0);
        step();
        expect_v("zero_stored1", 0, 32'h0);
        step();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hB; ra(5'd2, 5'd3);
        expect_v("prio_bypass", 1, 32'hB);
        step();
        expect_v("prio_stored", 1, 32'hB);
        step();
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hC4; ra(5'd4, 5'd4);
        expect_v("wd0_bypass", 1, 32'hC4);
        step();
        iss_en = 1'b1; iss_rd = 5'd5; ra(5'd5, 5'd3);
        expect_v("iss5_waw", 5, 32'h0);
        expect_v("iss5_busy_pre", 2, 32'h0);
        expect_v("iss5_cnt_pre", 4, 32'h0);
        step();
        expect_v("iss5_cnt", 4, 32'h1);
        expect_v("iss5_busy", 2, 32'h1);
        step();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h7;
        expect_v("wb5_busy", 2, 32'h0);
        expect_v("wb5_data", 0, 32'h7);
        expect_v("wb5_cnt_pre", 4, 32'h1);
        step();
        expect_v("wb5_cnt", 4, 32'h0);
        expect_v("wb5_busy_post", 2, 32'h0);
        expect_v("wb5_data_post", 0, 32'h7);
        step();
        iss_en = 1'b1; iss_rd = 5'd6; we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h66; ra(5'd5, 5'd6);
        step();
        expect_v("col6_cnt", 4, 32'h1);
        expect_v("col6_busy", 3, 32'h1);
        expect_v("col6_data", 1, 32'h66);
        step();
        iss_en = 1'b1; iss_rd = 5'd6;
        expect_v("col6_waw", 5, 32'h1);
        step();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
        expect_v("reiss6_cnt", 4, 32'h1);
        step();
        iss_en = 1'b1; iss_rd = 5'd0;
        expect_v("nonbusy_wr_cnt", 4, 32'h1);
        expect_v("iss0_waw", 5, 32'h0);
        step();
        iss_en = 1'b1; iss_rd = 5'd5;
        expect_v("iss0_cnt", 4, 32'h1);
        step();
        iss_en = 1'b1; iss_rd = 5'd7;
        step();
        ra(5'd7, 5'd6);
        expect_v("pre_rst_cnt", 4, 32'h3);
        expect_v("pre_rst_busy7", 2, 32'h1);
        step();
        reset_n = 1'b0;
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h88; iss_en = 1'b1; iss_rd = 5'd9;
        step();
        reset_n = 1'b1;
        ra(5'd2, 5'd3);
        expect_v("rst_cnt", 4, 32'h0);
        expect_v("rst_data2", 0, 32'h0);
        expect_v("rst_data3", 1, 32'h0);
        step();
        ra(5'd5, 5'd6);
        expect_v("rst_busy5", 2, 32'h0);
        expect_v("rst_busy6", 3, 32'h0);
        expect_v("rst_data6", 1, 32'h0);
        step();
        ra(5'd8, 5'd9);
        expect_v("rst_drop_wr", 0, 32'h0);
        expect_v("rst_drop_iss", 3, 32'h0);
        expect_v("rst_cnt2", 4, 32'h0);
        step();
        step();
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
